// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 message padder.
package sha2_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam int LEN_W   = 64;
  localparam int BPW_256 = 4;
  localparam int BPW_512 = 8;

  function automatic int bytes_per_word(input int ws);
    return ws / 8;
  endfunction

endpackage

// File: rtl/sha2_pad_word.sv
// Final-word shaping: keeps the first nbytes MSB-aligned bytes, places 0x80
// right after them and zeroes the rest. nbytes >= bytes-per-word passes data.
module sha2_pad_word #(
  parameter int WORDSIZE = 32
) (
  input  logic [WORDSIZE-1:0]         data,
  input  logic [$clog2(WORDSIZE/8):0] nbytes,
  output logic [WORDSIZE-1:0]         word
);
  localparam int BPW = WORDSIZE / 8;

  always_comb begin
    word = '0;
    for (int i = 0; i < BPW; i++) begin
      if (i < int'(nbytes))
        word[WORDSIZE-8-8*i +: 8] = data[WORDSIZE-8-8*i +: 8];
      else if (i == int'(nbytes))
        word[WORDSIZE-8-8*i +: 8] = 8'h80;
    end
  end

endmodule

// File: rtl/sha2_padder.sv
// SHA-2 padder: collects message words into a 16-word block, appends the 0x80
// marker, zero fill and 64-bit bit length. Option SHA2_PADDER_BYTE_EN honours in_bytes.
//
// state | meaning
// FILL  | accepting message words into buffer index idx
// PAD   | writing marker/zero words, one per cycle, up to idx 14
// LEN   | writing the bit length into words 14 and 15
// EMIT  | presenting the block on M until M_ready
module sha2_padder
  import sha2_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORDSIZE-1:0]         in_data,
  input  logic [$clog2(WORDSIZE/8):0] in_bytes,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WORDSIZE*16-1:0]      M,
  output logic                        M_valid,
  input  logic                        M_ready,
  output logic                        M_first,
  output logic                        M_last
);
  localparam int BPW = bytes_per_word(WORDSIZE);
  localparam int BW  = $clog2(BPW) + 1;
  localparam logic [WORDSIZE-1:0] MARK = {8'h80, {(WORDSIZE-8){1'b0}}};
  localparam logic [BW-1:0]       FULL = BW'(BPW);

  state_t                state;
  logic [3:0]            idx;
  logic [WORDSIZE-1:0]   buf_q [16];
  logic [LEN_W-1:0]      len_q;
  logic                  first_q;
  logic                  mark_q;   // 0x80 still owed to the next word
  logic                  tail_q;   // a length-only block must follow
  logic [BW-1:0]         bytes_sel;
  logic [BW-1:0]         word_bytes;
  logic                  last_full;
  logic [WORDSIZE-1:0]   padded;
  logic [LEN_W-1:0]      len_inc;
  logic [2*WORDSIZE-1:0] len_ext;

`ifdef SHA2_PADDER_BYTE_EN
  assign bytes_sel = (in_bytes > FULL) ? FULL : in_bytes;
`else
  logic unused_in_bytes;
  assign unused_in_bytes = ^in_bytes;
  assign bytes_sel       = FULL;
`endif

  assign word_bytes = in_last ? bytes_sel : FULL;
  assign last_full  = (word_bytes == FULL);
  assign len_inc    = LEN_W'(word_bytes) << 3;
  assign len_ext    = (2*WORDSIZE)'(len_q);

  sha2_pad_word #(.WORDSIZE(WORDSIZE)) u_pad_word (
    .data   (in_data),
    .nbytes (word_bytes),
    .word   (padded)
  );

  always_comb begin
    M = '0;
    for (int i = 0; i < 16; i++)
      M[WORDSIZE*(15-i) +: WORDSIZE] = buf_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      idx      <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      mark_q   <= 1'b0;
      tail_q   <= 1'b0;
      in_ready <= 1'b0;
      M_valid  <= 1'b0;
      M_first  <= 1'b0;
      M_last   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            buf_q[idx] <= padded;
            len_q      <= len_q + len_inc;
            if (!in_last) begin
              if (idx == 4'd15) begin
                state <= EMIT; in_ready <= 1'b0;
                M_valid <= 1'b1; M_first <= first_q; M_last <= 1'b0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else if (!last_full) begin
              if (idx >= 4'd14) begin
                // marker landed in the length slots: spill length to a second block
                tail_q <= 1'b1;
                state <= EMIT; in_ready <= 1'b0;
                M_valid <= 1'b1; M_first <= first_q; M_last <= 1'b0;
              end else begin
                idx      <= idx + 4'd1;
                state    <= (idx == 4'd13) ? LEN : PAD;
                in_ready <= 1'b0;
              end
            end else begin
              mark_q <= 1'b1;
              if (idx == 4'd15) begin
                state <= EMIT; in_ready <= 1'b0;
                M_valid <= 1'b1; M_first <= first_q; M_last <= 1'b0;
              end else begin
                idx      <= idx + 4'd1;
                state    <= PAD;
                in_ready <= 1'b0;
              end
            end
          end
        end

        PAD: begin
          buf_q[idx] <= mark_q ? MARK : '0;
          mark_q     <= 1'b0;
          if (mark_q && idx >= 4'd14) begin
            tail_q <= 1'b1;
            state <= EMIT;
            M_valid <= 1'b1; M_first <= first_q; M_last <= 1'b0;
          end else begin
            idx <= idx + 4'd1;
            if (idx == 4'd13) state <= LEN;
          end
        end

        LEN: begin
          buf_q[14] <= len_ext[2*WORDSIZE-1:WORDSIZE];
          buf_q[15] <= len_ext[WORDSIZE-1:0];
          tail_q    <= 1'b0;
          state     <= EMIT;
          M_valid   <= 1'b1; M_first <= first_q; M_last <= 1'b1;
        end

        EMIT: begin
          if (M_ready) begin
            M_valid <= 1'b0;
            M_first <= 1'b0;
            M_last  <= 1'b0;
            idx     <= '0;
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
            if (M_last) begin
              first_q <= 1'b1;
              len_q   <= '0;
            end else begin
              first_q <= 1'b0;
            end
            if (mark_q || tail_q) begin
              state <= PAD;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_padder.sv
// Directed bench for sha2_padder (32-bit instance plus a 64-bit instance).
module tb_sha2_padder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last, in_valid, in_ready;
  logic [511:0] M;
  logic         M_valid, M_ready, M_first, M_last;

  logic [63:0]   d64_data;
  logic [3:0]    d64_bytes;
  logic          d64_last, d64_valid, d64_ready;
  logic [1023:0] d64_M;
  logic          d64_M_valid, d64_M_ready, d64_M_first, d64_M_last;

  sha2_padder #(.WORDSIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_bytes(in_bytes),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .M(M), .M_valid(M_valid), .M_ready(M_ready), .M_first(M_first), .M_last(M_last)
  );

  sha2_padder #(.WORDSIZE(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_data(d64_data), .in_bytes(d64_bytes),
    .in_last(d64_last), .in_valid(d64_valid), .in_ready(d64_ready),
    .M(d64_M), .M_valid(d64_M_valid), .M_ready(d64_M_ready),
    .M_first(d64_M_first), .M_last(d64_M_last)
  );

  typedef struct {
    int          n;         // words in message
    logic [31:0] last_d;    // data of the final word
    logic [2:0]  last_b;    // in_bytes of the final word
    logic [31:0] exp_last;  // expected buffer content of the final word
    int          mark;      // flat word index of a separate 0x80 word, -1 if none
    int          nblk;
    logic [31:0] exp_len;
  } vec_t;

  localparam int NV = 8;
  vec_t        vecs [NV];
  logic [31:0] exp_w [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] pat(input int j);
    return 32'hC0DE0000 | 32'(j);
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_block(input int b);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[(15-i)*32 +: 32] = exp_w[b*16+i];
    return r;
  endfunction

  task automatic build_exp(input vec_t v);
    for (int i = 0; i < 32; i++) exp_w[i] = '0;
    for (int j = 0; j < v.n - 1; j++) exp_w[j] = pat(j);
    exp_w[v.n-1] = v.exp_last;
    if (v.mark >= 0) exp_w[v.mark] = 32'h80000000;
    exp_w[v.nblk*16-1] = v.exp_len;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] m, output logic f, output logic l);
    int t;
    t = 0;
    while (!M_valid && t < 200) begin @(negedge clk); t++; end
    if (!M_valid) begin
      n_tests++; n_fail++;
      $display("FAIL block_timeout: M_valid stayed 0, required 1");
    end
    m = M; f = M_first; l = M_last;
    M_ready = 1'b1;
    @(negedge clk);
    M_ready = 1'b0;
  endtask

  task automatic run_vec(input int k);
    logic [511:0] m;
    logic f, l;
    build_exp(vecs[k]);
    for (int j = 0; j < vecs[k].n - 1; j++) send_word(pat(j), 1'b0, 3'd4);
    send_word(vecs[k].last_d, 1'b1, vecs[k].last_b);
    for (int b = 0; b < vecs[k].nblk; b++) begin
      get_block(m, f, l);
      check($sformatf("v%0d_b%0d_M", k, b), m, exp_block(b));
      check($sformatf("v%0d_b%0d_first", k, b), 512'(f), 512'(b == 0));
      check($sformatf("v%0d_b%0d_last", k, b), 512'(l), 512'(b == vecs[k].nblk - 1));
    end
    check($sformatf("v%0d_valid_drop", k), 512'(M_valid), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] m0, m;
    logic f, l;
    logic [63:0] e64 [16];
    int t;

`ifdef SHA2_PADDER_BYTE_EN
    vecs[0] = '{1,  32'h61626300, 3'd3, 32'h61626380, -1, 1, 32'h18};
    vecs[1] = '{1,  32'hDEADBEEF, 3'd0, 32'h80000000, -1, 1, 32'h0};
    vecs[2] = '{14, pat(13),      3'd4, pat(13),      14, 2, 32'h1C0};
    vecs[3] = '{14, 32'h11223344, 3'd2, 32'h11228000, -1, 1, 32'h1B0};
    vecs[4] = '{15, 32'hAABBCCDD, 3'd1, 32'hAA800000, -1, 2, 32'h1C8};
    vecs[5] = '{16, pat(15),      3'd4, pat(15),      16, 2, 32'h200};
    vecs[6] = '{16, 32'h01020304, 3'd3, 32'h01020380, -1, 2, 32'h1F8};
    vecs[7] = '{13, pat(12),      3'd4, pat(12),      13, 1, 32'h1A0};
`else
    vecs[0] = '{1,  32'h61626300, 3'd3, 32'h61626300, 1,  1, 32'h20};
    vecs[1] = '{1,  32'hDEADBEEF, 3'd0, 32'hDEADBEEF, 1,  1, 32'h20};
    vecs[2] = '{14, pat(13),      3'd4, pat(13),      14, 2, 32'h1C0};
    vecs[3] = '{14, 32'h11223344, 3'd2, 32'h11223344, 14, 2, 32'h1C0};
    vecs[4] = '{15, 32'hAABBCCDD, 3'd1, 32'hAABBCCDD, 15, 2, 32'h1E0};
    vecs[5] = '{16, pat(15),      3'd4, pat(15),      16, 2, 32'h200};
    vecs[6] = '{16, 32'h01020304, 3'd3, 32'h01020304, 16, 2, 32'h200};
    vecs[7] = '{13, pat(12),      3'd4, pat(12),      13, 1, 32'h1A0};
`endif

    rst_n = 1'b0;
    in_data = '0; in_bytes = '0; in_last = 1'b0; in_valid = 1'b0; M_ready = 1'b0;
    d64_data = '0; d64_bytes = '0; d64_last = 1'b0; d64_valid = 1'b0; d64_M_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'(0));
    check("rst_M_valid",  512'(M_valid),  512'(0));
    check("rst_M_first",  512'(M_first),  512'(0));
    check("rst_M_last",   512'(M_last),   512'(0));
    check("rst_M",        M,              512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 512'(in_ready), 512'(1));

    for (int k = 0; k < NV; k++) run_vec(k);

    // Backpressure: block held 5 cycles while the next message's word waits
    build_exp(vecs[0]);
    send_word(vecs[0].last_d, 1'b1, vecs[0].last_b);
    t = 0;
    while (!M_valid && t < 200) begin @(negedge clk); t++; end
    m0 = M;
    in_valid = 1'b1; in_data = vecs[0].last_d; in_last = 1'b1; in_bytes = vecs[0].last_b;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_M_stable", c), M, m0);
      check($sformatf("bp%0d_M_valid", c), 512'(M_valid), 512'(1));
      check($sformatf("bp%0d_in_ready", c), 512'(in_ready), 512'(0));
    end
    check("bp_M", M, exp_block(0));
    check("bp_first", 512'(M_first), 512'(1));
    M_ready = 1'b1;
    @(negedge clk);
    M_ready = 1'b0;
    check("bp_in_ready_back", 512'(in_ready), 512'(1));
    @(negedge clk);
    in_valid = 1'b0;
    get_block(m, f, l);
    check("bp_next_M", m, exp_block(0));
    check("bp_next_first", 512'(f), 512'(1));
    check("bp_next_last", 512'(l), 512'(1));

    // Reset after 7 accepted words discards them and their length
    for (int j = 0; j < 7; j++) send_word(pat(j), 1'b0, 3'd4);
    rst_n = 1'b0;
    #1;
    check("midmsg_rst_M", M, 512'(0));
    check("midmsg_rst_in_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    // Reset while a block is being offered
    send_word(vecs[0].last_d, 1'b1, vecs[0].last_b);
    t = 0;
    while (!M_valid && t < 200) begin @(negedge clk); t++; end
    check("emit_before_rst_valid", 512'(M_valid), 512'(1));
    rst_n = 1'b0;
    #1;
    check("emit_rst_M_valid", 512'(M_valid), 512'(0));
    check("emit_rst_M", M, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    // 64-bit instance, "abc"
    for (int i = 0; i < 16; i++) e64[i] = '0;
`ifdef SHA2_PADDER_BYTE_EN
    e64[0]  = 64'h6162638000000000;
    e64[15] = 64'h18;
`else
    e64[0]  = 64'h6162630000000000;
    e64[1]  = 64'h8000000000000000;
    e64[15] = 64'h40;
`endif
    d64_valid = 1'b1; d64_data = 64'h6162630000000000; d64_last = 1'b1; d64_bytes = 4'd3;
    t = 0;
    while (!d64_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    d64_valid = 1'b0;
    t = 0;
    while (!d64_M_valid && t < 200) begin @(negedge clk); t++; end
    check("w64_M_valid", 512'(d64_M_valid), 512'(1));
    for (int i = 0; i < 16; i++)
      check($sformatf("w64_word%0d", i), 512'(d64_M[64*(15-i) +: 64]), 512'(e64[i]));
    check("w64_first", 512'(d64_M_first), 512'(1));
    check("w64_last",  512'(d64_M_last),  512'(1));
    d64_M_ready = 1'b1;
    @(negedge clk);
    d64_M_ready = 1'b0;
    check("w64_valid_drop", 512'(d64_M_valid), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
